alu_mc: RTL and testbench
=========================

Name: alu_mc

Overview:
- Parametrised multi-cycle successor to the single-cycle datapath ALU.
- Executes the existing op set (AND, OR, ADD, SUB, SLT, SRLV, PASSA) with a registered result.
- Adds iterative unsigned multiply (MULTU) and, optionally, iterative unsigned divide (DIVU), both producing HI/LO.
- Sits between the register-read stage and writeback of the multi-cycle core, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 32: operand and result width; must be ≥ 4 and a power of two.
- CNT_W, $clog2(WIDTH)+1: iteration counter width; derived, do not override.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operation request valid
- in_ready  out  1  block can accept a request
- op  in  4  operation code (encodings in Behaviour)
- a  in  WIDTH  operand A ($rs)
- b  in  WIDTH  operand B ($rt or imm)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- result  out  WIDTH  primary result; LO for MULTU/DIVU
- result_hi  out  WIDTH  HI for MULTU (upper product) and DIVU (remainder); 0 for other ops
- zout  out  1  result == 0 (primary result only)
- err  out  1  illegal op, or DIVU with divisor 0

Behaviour:
- Op encodings:
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB (a + ~b + 1).
  - 0111 SLT: signed compare, result 1 if a < b else 0. Use the true signed comparison, not just the sign bit of a − b.
  - 0101 SRLV: b >> a[CNT_W-2:0].
  - 0011 PASSA: result = a.
  - 1000 MULTU, 1001 DIVU.
  - Any other op is illegal: result = 0, result_hi = 0, err = 1, latency 1.
- All arithmetic is modulo 2^WIDTH; ADD/SUB carry and overflow are discarded.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state == IDLE).
  - Request accepted on in_valid && in_ready; a, b and op are captured.
  - IDLE → DONE for simple ops. The result is registered, so out_valid is asserted the cycle after acceptance.
  - IDLE → BUSY for MULTU/DIVU; counter loads WIDTH.
  - BUSY: one shift-add (MULTU) or one restoring-subtract step (DIVU) per cycle; counter decrements; at counter == 1 → DONE.
  - Iterative ops therefore assert out_valid WIDTH cycles after acceptance.
  - DONE: out_valid = 1; result, result_hi, zout and err are held stable until out_valid && out_ready, then → IDLE.
  - A new request is not accepted in the same cycle as the handshake, so the maximum rate is one op per 2 cycles.
- DIVU with b == 0: skip BUSY, go directly to DONE with latency 1. result = all-ones, result_hi = a, err = 1.
- zout and err are registered alongside result and change only on entry to DONE.
- Reset (asynchronous, any state, including mid-iteration):
  - state = IDLE, counter = 0.
  - result, result_hi, zout, err = 0; out_valid = 0.
  - Any in-flight operation is discarded and no partial result is exposed.
  - in_ready becomes 1 in the first clock cycle after rst_n deasserts.
- in_valid while not in IDLE is ignored. The operands are not sampled and there is no error.
- op, a and b changing during BUSY has no effect, because the captured copies are used.

Optional Feature:
- Macro: ALU_MC_DIV_EN.
- Defined: the DIVU iterative divider and its datapath (shared counter, remainder register) are compiled in.
- Undefined: op 1001 is treated as illegal (err = 1, result = 0, result_hi = 0, latency 1) and no divider logic is generated. MULTU is unaffected.

Decomposition:
- Shared package alu_mc_pkg: 4-bit op encoding constants (OP_AND … OP_DIVU) and the state encoding (IDLE/BUSY/DONE). The control unit decoder reuses the op constants.
- One natural sub-module: alu_mc_iter. It holds the shift-add/restoring-divide step datapath with acc/hi/lo registers, a start input and a done pulse output. The top level keeps the FSM, handshake, simple-op logic and output registers.

Test Plan (WIDTH = 32):
- ADD a=0x7FFFFFFF, b=1 → out_valid 1 cycle after accept, result=0x80000000, zout=0, err=0. SUB a=5, b=5 → result=0, zout=1.
- SLT a=0xFFFFFFFF (−1), b=1 → result=1. SLT a=0x7FFFFFFF, b=0x80000000 → result=0. SRLV a=4, b=0xF0 → result=0x0F.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → out_valid exactly 32 cycles after accept, result_hi=0xFFFFFFFE, result=0x00000001. in_ready=0 throughout BUSY.
- DIVU a=100, b=7 → result=14, result_hi=2 after 32 cycles. DIVU b=0, a=9 → result=0xFFFFFFFF, result_hi=9, err=1 at latency 1. Without ALU_MC_DIV_EN: op 1001 → err=1, result=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → outputs stable and in_ready=0; raise out_ready → out_valid drops next cycle and in_ready=1.
- Assert rst_n=0 at cycle 10 of a MULTU → all outputs 0 immediately. After release, a new ADD 2+3 → result=5 with no stale MULTU result appearing. Illegal op 1111 → err=1, result=0.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: definitions shared by the multi-cycle ALU.
//   - 4-bit op encodings. The control unit decoder reuses these.
//   - The FSM state encoding of alu_mc (IDLE/BUSY/DONE).
// Optional divider build macro: ALU_MC_DIV_EN. It is consumed by alu_mc and alu_mc_iter.
package alu_mc_pkg;

    // Op encodings. Any value not listed here is an illegal op.
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_PASSA = 4'b0011;
    localparam logic [3:0] OP_SRLV  = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_MULTU = 4'b1000;
    localparam logic [3:0] OP_DIVU  = 4'b1001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    // An op is iterative when it must run through the shift/subtract datapath.
    // A DIVU with a zero divisor is resolved in one cycle by the caller.
    function automatic logic op_is_iter(input logic [3:0] op);
        logic w_iter;
        w_iter = (op == OP_MULTU);
`ifdef ALU_MC_DIV_EN
        w_iter = w_iter || (op == OP_DIVU);
`endif
        return w_iter;
    endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// alu_mc_iter: iterative datapath for unsigned multiply (shift-add) and, when
// ALU_MC_DIV_EN is defined, unsigned restoring divide.
//
// The first step is taken on the i_start edge directly from the operands. The
// remaining WIDTH-1 steps follow on consecutive cycles. o_done is high during
// the cycle whose step is the last one. o_hi/o_lo carry that step's
// (combinational) outcome, so the caller registers them on the same edge.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   i_start      load operands and perform the first step
//   i_div        (ALU_MC_DIV_EN only) 1 = divide, 0 = multiply
//   i_a, i_b     operands: multiplicand/multiplier or dividend/divisor
//   o_done       final step happens this cycle
//   o_hi, o_lo   post-step HI (product high / remainder) and LO (product low / quotient)
module alu_mc_iter
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
`ifdef ALU_MC_DIV_EN
    input  logic             i_div,
`endif
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

    // r_acc: HI half (partial product / partial remainder)
    // r_lo:  LO half (multiplier being shifted out / dividend becoming quotient)
    // r_opnd: multiplicand or divisor
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_opnd;
    logic [CNT_W-1:0] r_cnt;

    logic [WIDTH-1:0] w_acc_cur;
    logic [WIDTH-1:0] w_lo_cur;
    logic [WIDTH-1:0] w_opnd_cur;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic [WIDTH:0]   w_sum;

`ifdef ALU_MC_DIV_EN
    logic             r_div;
    logic             w_div_cur;
    logic [WIDTH:0]   w_rem_sh;
    logic [WIDTH:0]   w_diff;
`endif

    always_comb begin
        // On start the step works from the incoming operands with a cleared accumulator.
        w_acc_cur = i_start ? '0 : r_acc;
`ifdef ALU_MC_DIV_EN
        w_div_cur  = i_start ? i_div : r_div;
        w_lo_cur   = i_start ? (i_div ? i_a : i_b) : r_lo;
        w_opnd_cur = i_start ? (i_div ? i_b : i_a) : r_opnd;
`else
        w_lo_cur   = i_start ? i_b : r_lo;
        w_opnd_cur = i_start ? i_a : r_opnd;
`endif

        // Shift-add: conditionally add the multiplicand, then shift {carry, acc, lo} right.
        w_sum = {1'b0, w_acc_cur} + (w_lo_cur[0] ? {1'b0, w_opnd_cur} : '0);
        {w_acc_nxt, w_lo_nxt} = {w_sum, w_lo_cur[WIDTH-1:1]};

`ifdef ALU_MC_DIV_EN
        // Restoring divide: shift the next dividend bit into the remainder and try
        // subtracting. A borrow (top bit set) means keep the shifted remainder.
        w_rem_sh = {w_acc_cur, w_lo_cur[WIDTH-1]};
        w_diff   = w_rem_sh - {1'b0, w_opnd_cur};
        if (w_div_cur) begin
            if (!w_diff[WIDTH]) begin
                w_acc_nxt = w_diff[WIDTH-1:0];
                w_lo_nxt  = {w_lo_cur[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_nxt = w_rem_sh[WIDTH-1:0];
                w_lo_nxt  = {w_lo_cur[WIDTH-2:0], 1'b0};
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_lo   <= '0;
            r_opnd <= '0;
            r_cnt  <= '0;
`ifdef ALU_MC_DIV_EN
            r_div  <= 1'b0;
`endif
        end else if (i_start) begin
            r_acc  <= w_acc_nxt;
            r_lo   <= w_lo_nxt;
            r_opnd <= w_opnd_cur;
            r_cnt  <= CNT_LOAD;
`ifdef ALU_MC_DIV_EN
            r_div  <= i_div;
`endif
        end else if (r_cnt != '0) begin
            r_acc <= w_acc_nxt;
            r_lo  <= w_lo_nxt;
            r_cnt <= r_cnt - CNT_ONE;
        end
    end

    assign o_done = (r_cnt == CNT_ONE);
    assign o_hi   = w_acc_nxt;
    assign o_lo   = w_lo_nxt;

endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU between register read and writeback.
//
// Simple ops (AND, OR, ADD, SUB, SLT, SRLV, PASSA) and illegal ops complete in
// one cycle. MULTU, and DIVU when ALU_MC_DIV_EN is defined, run through
// alu_mc_iter and present a result WIDTH cycles after acceptance. DIVU with a
// zero divisor completes in one cycle with err set. Without ALU_MC_DIV_EN, DIVU
// is an illegal op.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake; in_ready is high only in IDLE
//   op, a, b              operation and operands, captured on acceptance
//   out_valid / out_ready result handshake; outputs are held while out_valid
//   result                primary result (LO for MULTU/DIVU)
//   result_hi             HI for MULTU/DIVU, 0 otherwise
//   zout                  result == 0
//   err                   illegal op or divide by zero
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zout,
    output logic             err
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           r_state;
    logic [WIDTH-1:0] r_result;
    logic [WIDTH-1:0] r_result_hi;
    logic             r_zout;
    logic             r_err;

    logic [WIDTH-1:0] w_simple_res;
    logic [WIDTH-1:0] w_simple_hi;
    logic             w_simple_err;
    logic             w_is_iter;
    logic             w_start;
    logic             w_iter_done;
    logic [WIDTH-1:0] w_iter_hi;
    logic [WIDTH-1:0] w_iter_lo;

    // Single-cycle result for everything that does not need the iterative datapath.
    always_comb begin
        w_simple_res = '0;
        w_simple_hi  = '0;
        w_simple_err = 1'b0;
        w_is_iter    = op_is_iter(op);
        case (op)
            OP_AND:   w_simple_res = a & b;
            OP_OR:    w_simple_res = a | b;
            OP_ADD:   w_simple_res = a + b;
            OP_SUB:   w_simple_res = a + ~b + ONE;
            // True signed compare; the sign of a - b is wrong on overflow.
            OP_SLT:   w_simple_res = ($signed(a) < $signed(b)) ? ONE : '0;
            OP_SRLV:  w_simple_res = b >> a[CNT_W-2:0];
            OP_PASSA: w_simple_res = a;
            OP_MULTU: w_simple_res = '0;
`ifdef ALU_MC_DIV_EN
            OP_DIVU: begin
                // Divide by zero bypasses the divider.
                if (b == '0) begin
                    w_is_iter    = 1'b0;
                    w_simple_res = '1;
                    w_simple_hi  = a;
                    w_simple_err = 1'b1;
                end
            end
`endif
            default:  w_simple_err = 1'b1;
        endcase
    end

    assign w_start = in_valid && (r_state == IDLE) && w_is_iter;

    alu_mc_iter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_iter (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_start (w_start),
`ifdef ALU_MC_DIV_EN
        .i_div   (op == OP_DIVU),
`endif
        .i_a     (a),
        .i_b     (b),
        .o_done  (w_iter_done),
        .o_hi    (w_iter_hi),
        .o_lo    (w_iter_lo)
    );

    // Control FSM and result registers. Result, HI, zout and err only change on
    // entry to DONE, so they stay stable for the whole output handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_result    <= '0;
            r_result_hi <= '0;
            r_zout      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        if (w_is_iter) begin
                            r_state <= BUSY;
                        end else begin
                            r_state     <= DONE;
                            r_result    <= w_simple_res;
                            r_result_hi <= w_simple_hi;
                            r_zout      <= (w_simple_res == '0);
                            r_err       <= w_simple_err;
                        end
                    end
                end
                BUSY: begin
                    if (w_iter_done) begin
                        r_state     <= DONE;
                        r_result    <= w_iter_lo;
                        r_result_hi <= w_iter_hi;
                        r_zout      <= (w_iter_lo == '0);
                        r_err       <= 1'b0;
                    end
                end
                DONE: begin
                    // No new acceptance on the handshake cycle: go back to IDLE first.
                    if (out_ready) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = (r_state == DONE);
    assign result    = r_result;
    assign result_hi = r_result_hi;
    assign zout      = r_zout;
    assign err       = r_err;

endmodule

// File: tb/tb_alu_mc.sv
module tb_alu_mc;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] result;
    logic [W-1:0] result_hi;
    logic         zout;
    logic         err;

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .result_hi (result_hi),
        .zout      (zout),
        .err       (err)
    );

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what the op must produce and after how many cycles.
    function automatic void model(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                                  output logic [W-1:0] r, output logic [W-1:0] h,
                                  output logic e, output int lat);
        logic [2*W-1:0] prod;
        r = '0; h = '0; e = 1'b0; lat = 1;
        case (o)
            4'b0000: r = x & y;
            4'b0001: r = x | y;
            4'b0010: r = x + y;
            4'b0110: r = x - y;
            4'b0111: r = ($signed(x) < $signed(y)) ? 1 : 0;
            4'b0101: r = y >> (x % W);
            4'b0011: r = x;
            4'b1000: begin
                prod = {{W{1'b0}}, x} * {{W{1'b0}}, y};
                r = prod[W-1:0];
                h = prod[2*W-1:W];
                lat = W;
            end
`ifdef ALU_MC_DIV_EN
            4'b1001: begin
                if (y == 0) begin
                    r = '1; h = x; e = 1'b1;
                end else begin
                    r = x / y; h = x % y; lat = W;
                end
            end
`endif
            default: e = 1'b1;
        endcase
    endfunction

    // Model state: 0 = idle, 1 = computing, 2 = presenting a result.
    int           m_phase = 0;
    int           m_left = 0;
    logic [W-1:0] m_res = '0;
    logic [W-1:0] m_hi = '0;
    logic         m_err = 1'b0;
    logic [W-1:0] t_r, t_h;
    logic         t_e;
    int           t_l;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_left  <= 0;
        end else begin
            case (m_phase)
                0: if (in_valid) begin
                    model(op, a, b, t_r, t_h, t_e, t_l);
                    m_res <= t_r;
                    m_hi  <= t_h;
                    m_err <= t_e;
                    if (t_l == 1) begin
                        m_phase <= 2;
                    end else begin
                        m_phase <= 1;
                        m_left  <= t_l - 1;
                    end
                end
                1: begin
                    if (m_left == 1) m_phase <= 2;
                    m_left <= m_left - 1;
                end
                default: if (out_ready) m_phase <= 0;
            endcase
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("in_ready", in_ready, m_phase == 0);
            check("out_valid", out_valid, m_phase == 2);
            if (m_phase == 2) begin
                check("result", result, m_res);
                check("result_hi", result_hi, m_hi);
                check("err", err, m_err);
                check("zout", zout, m_res == 0);
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        in_valid = 1'b1; op = o; a = x; b = y;
        @(posedge clk); #1;
        // Scramble the inputs so any use of uncaptured operands shows up.
        in_valid = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom;
    endtask

    task automatic run(input logic [3:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic [W-1:0] er, input logic [W-1:0] eh, input logic ez,
                       input logic ee, input int el, input int hold, input string nm);
        int lat;
        issue(o, x, y);
        lat = 1;
        while (!out_valid && lat < 80) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, lat, el);
        check({nm, "_result"}, result, er);
        check({nm, "_result_hi"}, result_hi, eh);
        check({nm, "_zout"}, zout, ez);
        check({nm, "_err"}, err, ee);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({nm, "_hold_in_ready"}, in_ready, 1'b0);
            check({nm, "_hold_valid"}, out_valid, 1'b1);
            check({nm, "_hold_result"}, result, er);
            check({nm, "_hold_hi"}, result_hi, eh);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({nm, "_drop_valid"}, out_valid, 1'b0);
        check({nm, "_ready_back"}, in_ready, 1'b1);
    endtask

    function automatic logic [W-1:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return W'($urandom_range(0, 15));
            3: return 32'h8000_0000 | W'($urandom_range(0, 3));
            default: return $urandom;
        endcase
    endfunction

    logic [3:0] ops [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                             4'b0011, 4'b1000, 4'b1001, 4'b0100, 4'b1111, 4'b1010};

    initial begin
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_result", result, 0);
        check("rst_result_hi", result_hi, 0);
        check("rst_zout", zout, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        cmp_en = 1'b1;

        run(4'b0010, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 0, 0, 0, 1, 0, "add_ovf");
        run(4'b0110, 32'd5, 32'd5, 0, 0, 1, 0, 1, 0, "sub_zero");
        run(4'b0111, 32'hFFFF_FFFF, 32'h1, 1, 0, 0, 0, 1, 0, "slt_neg");
        run(4'b0111, 32'h7FFF_FFFF, 32'h8000_0000, 0, 0, 1, 0, 1, 0, "slt_ovf");
        run(4'b0101, 32'd4, 32'hF0, 32'h0F, 0, 0, 0, 1, 0, "srlv");
        run(4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 0, 0, 0, 1, 0, "and");
        run(4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0, 0, 0, 0, 1, 0, "or");
        run(4'b0011, 32'h1234_5678, 32'h0, 32'h1234_5678, 0, 0, 0, 1, 0, "passa");
        run(4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFE, 0, 0, 32, 0, "multu_max");
        run(4'b1000, 32'd0, 32'd5, 0, 0, 1, 0, 32, 0, "multu_zero");
        run(4'b1111, 32'd3, 32'd4, 0, 0, 1, 1, 1, 0, "illegal");
`ifdef ALU_MC_DIV_EN
        run(4'b1001, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 32, 0, "divu");
        run(4'b1001, 32'd9, 32'd0, 32'hFFFF_FFFF, 32'd9, 0, 1, 1, 0, "divu_by0");
`else
        run(4'b1001, 32'd100, 32'd7, 0, 0, 1, 1, 1, 0, "divu_off");
`endif
        // Backpressure: 2^16 * 2^16 = 2^32 -> HI 1, LO 0.
        run(4'b1000, 32'h0001_0000, 32'h0001_0000, 0, 32'h1, 1, 0, 32, 10, "bp_multu");

        // Reset in the middle of a multiply.
        issue(4'b1000, 32'hFFFF_FFFF, 32'h0000_0003);
        repeat (9) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_result", result, 0);
        check("midrst_result_hi", result_hi, 0);
        check("midrst_zout", zout, 0);
        check("midrst_err", err, 0);
        check("midrst_out_valid", out_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        run(4'b0010, 32'd2, 32'd3, 32'd5, 0, 0, 0, 1, 0, "add_after_rst");
        // Nothing stale may surface after the aborted multiply.
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1 out_ready = 1'b0;

        // Randomized traffic with random backpressure, checked by the model.
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = ops[$urandom_range(0, 11)];
            a         = rnd_val();
            b         = rnd_val();
            out_ready = $urandom_range(0, 1) == 1;
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
